// File: rtl/lstm_cell_update.sv
// lstm_cell_update
//
// Purpose:
//   Back end of one LSTM cell. It sits after the four gate multiply-add stages
//   and takes their pre-activations zi/zf/zg/zo (signed fixed point, Q8.8 at
//   the default parameters). It applies piecewise-linear activations, updates
//   the internal cell state c, and produces h = o * tanh(c). All multiplies go
//   through one shared fixed-point multiplier, which a small FSM steps through
//   one operation per cycle.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   zi/zf/zg/zo/clear_state are valid
//   in_ready     out  block can accept an element (only while idle)
//   clear_state  in   use 0 instead of the stored cell state for this element
//   zi,zf,zg,zo  in   input/forget/candidate/output gate pre-activations
//   out_valid    out  h_out/c_out hold a finished result
//   out_ready    in   consumer takes the result
//   h_out        out  hidden state h
//   c_out        out  updated cell state c
module lstm_cell_update #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear_state,
  input  logic [DATA_WIDTH-1:0] zi,
  input  logic [DATA_WIDTH-1:0] zf,
  input  logic [DATA_WIDTH-1:0] zg,
  input  logic [DATA_WIDTH-1:0] zo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] h_out,
  output logic [DATA_WIDTH-1:0] c_out
);

  // One guard bit on top of the data width keeps activation and sum
  // intermediates from overflowing before they are clamped.
  localparam int XW = DATA_WIDTH + 1;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [XW-1:0] ONE_X =
    {{(XW-FRACT_WIDTH-1){1'b0}}, 1'b1, {FRACT_WIDTH{1'b0}}};
  localparam logic signed [XW-1:0] HALF_X =
    {{(XW-FRACT_WIDTH){1'b0}}, 1'b1, {(FRACT_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] NEG_ONE_X = -ONE_X;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_MULF,
    S_MULI,
    S_ADD,
    S_MULO,
    S_DONE
  } state_t;

  // Hard sigmoid: (x/4 + 1/2) clamped to [0, 1].
  function automatic logic [DATA_WIDTH-1:0] hsig(input logic [DATA_WIDTH-1:0] x);
    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] s;
    xe = {x[DATA_WIDTH-1], x};
    s  = (xe >>> 2) + HALF_X;
    if (s[XW-1]) begin
      s = '0;
    end else if (s > ONE_X) begin
      s = ONE_X;
    end
    return s[DATA_WIDTH-1:0];
  endfunction

  // Hard tanh: x clamped to [-1, 1].
  function automatic logic [DATA_WIDTH-1:0] htanh(input logic [DATA_WIDTH-1:0] x);
    logic signed [XW-1:0] xe;
    xe = {x[DATA_WIDTH-1], x};
    if (xe > ONE_X) begin
      xe = ONE_X;
    end else if (xe < NEG_ONE_X) begin
      xe = NEG_ONE_X;
    end
    return xe[DATA_WIDTH-1:0];
  endfunction

  // Fixed-point multiply. Operands are sign-extended to the full product width
  // so the low product bits are the exact signed product; the result keeps the
  // low DATA_WIDTH bits after dropping the fraction. Only f*c can exceed that
  // range in principle, and |f| <= 1 keeps it inside.
  function automatic logic [DATA_WIDTH-1:0] fx_mul(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    logic signed [PW-1:0] prod;
    ae   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    be   = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    prod = ae * be;
    prod = prod >>> FRACT_WIDTH;
    return prod[DATA_WIDTH-1:0];
  endfunction

  // Saturating add: the guard bit differs from the data sign bit exactly
  // when the sum left the representable range.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic signed [XW-1:0] sum;
    sum = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
    if (sum[XW-1] != sum[XW-2]) begin
      return sum[XW-1] ? SAT_MIN : SAT_MAX;
    end
    return sum[DATA_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] i_q, i_d;
  logic [DATA_WIDTH-1:0] f_q, f_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [DATA_WIDTH-1:0] o_q, o_d;
  logic                  clr_q, clr_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] c_prev_q, c_prev_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] h_out_q, h_out_d;
  logic [DATA_WIDTH-1:0] c_out_q, c_out_d;

  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_b;
  logic [DATA_WIDTH-1:0] mul_r;
  logic [DATA_WIDTH-1:0] c_new;

  // State register. Reset wins in every state, dropping any element in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a fixed walk through the datapath steps, with the only
  // waits being for an input in IDLE and for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ACT;
      S_ACT:   state_d = S_MULF;
      S_MULF:  state_d = S_MULI;
      S_MULI:  state_d = S_ADD;
      S_ADD:   state_d = S_MULO;
      S_MULO:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state, so there is no path
  // from out_ready to in_ready.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Shared multiplier operand select. Outside the three multiply states the
  // operands are don't-care and are tied to zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MULF: begin
        mul_a = f_q;
        mul_b = c_prev_q;
      end
      S_MULI: begin
        mul_a = i_q;
        mul_b = g_q;
      end
      S_MULO: begin
        mul_a = o_q;
        mul_b = htanh(c_q);
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
    mul_r = fx_mul(mul_a, mul_b);
    c_new = sat_add(p_q, q_q);
  end

  // Datapath register updates, one step per FSM state. Everything holds
  // otherwise, which is what keeps h_out/c_out stable in DONE and after the
  // handshake.
  always_comb begin
    i_d      = i_q;
    f_d      = f_q;
    g_d      = g_q;
    o_d      = o_q;
    clr_d    = clr_q;
    c_d      = c_q;
    c_prev_d = c_prev_q;
    p_d      = p_q;
    q_d      = q_q;
    h_out_d  = h_out_q;
    c_out_d  = c_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          i_d   = hsig(zi);
          f_d   = hsig(zf);
          g_d   = htanh(zg);
          o_d   = hsig(zo);
          clr_d = clear_state;
        end
      end
      S_ACT: begin
        c_prev_d = clr_q ? '0 : c_q;
      end
      S_MULF: begin
        p_d = mul_r;
      end
      S_MULI: begin
        q_d = mul_r;
      end
      S_ADD: begin
        c_d     = c_new;
        c_out_d = c_new;
      end
      S_MULO: begin
        h_out_d = mul_r;
      end
      default: begin
        c_d = c_q;
      end
    endcase
  end

  // Datapath registers. Cell state and the visible outputs clear on reset;
  // gate and product registers are cleared too so nothing stale is observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      f_q      <= '0;
      g_q      <= '0;
      o_q      <= '0;
      clr_q    <= 1'b0;
      c_q      <= '0;
      c_prev_q <= '0;
      p_q      <= '0;
      q_q      <= '0;
      h_out_q  <= '0;
      c_out_q  <= '0;
    end else begin
      i_q      <= i_d;
      f_q      <= f_d;
      g_q      <= g_d;
      o_q      <= o_d;
      clr_q    <= clr_d;
      c_q      <= c_d;
      c_prev_q <= c_prev_d;
      p_q      <= p_d;
      q_q      <= q_d;
      h_out_q  <= h_out_d;
      c_out_q  <= c_out_d;
    end
  end

  assign h_out = h_out_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_lstm_cell_update.sv
// tb_lstm_cell_update
//
// Purpose:
//   Self-checking bench for lstm_cell_update. Directed elements cover reset,
//   a fresh sequence, carried state, half gates, saturation, backpressure and
//   reset mid-computation; a randomized phase follows. Expected results come
//   from an integer model of the LSTM cell update.
//
// Ports: none (top-level bench).
module tb_lstm_cell_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clear_state = 1'b0;
  logic [15:0] zi = '0;
  logic [15:0] zf = '0;
  logic [15:0] zg = '0;
  logic [15:0] zo = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] h_out;
  logic [15:0] c_out;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the cell state c as a plain integer, plus expected outputs.
  int          c_model = 0;
  logic [15:0] exp_h = '0;
  logic [15:0] exp_c = '0;

  lstm_cell_update #(
    .DATA_WIDTH (16),
    .FRACT_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear_state(clear_state),
    .zi         (zi),
    .zf         (zf),
    .zg         (zg),
    .zo         (zo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .h_out      (h_out),
    .c_out      (c_out)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on plain integers: real-valued rules scaled by 256.
  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int hsig_m(input int x);
    return clampi((x >>> 2) + 128, 0, 256);
  endfunction

  function automatic int htanh_m(input int x);
    return clampi(x, -256, 256);
  endfunction

  function automatic int mul_m(input int a, input int b);
    int          r;
    logic [15:0] t;
    r = (a * b) >>> 8;
    t = r[15:0];
    return sx(t);
  endfunction

  task automatic modelStep(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] cg, input logic [15:0] d,
                           input logic clr);
    int gi, gf, gg, go, cp, h;
    gi = hsig_m(sx(a));
    gf = hsig_m(sx(b));
    gg = htanh_m(sx(cg));
    go = hsig_m(sx(d));
    cp = clr ? 0 : c_model;
    c_model = clampi(mul_m(gf, cp) + mul_m(gi, gg), -32768, 32767);
    h = mul_m(go, htanh_m(c_model));
    exp_c = c_model[15:0];
    exp_h = h[15:0];
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Pushes one element, checks latency and the result, holds the result for
  // 'hold' cycles (optionally poking in_valid with junk meanwhile), then
  // completes the handshake. With 'early' set, out_ready is already high
  // before the result exists.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] cg, input logic [15:0] d,
                               input logic clr, input bit early,
                               input int hold, input bit poke);
    int cycles;
    @(negedge clk);
    checkOutput("in_ready_idle", {15'b0, in_ready}, 16'h0001);
    in_valid    = 1'b1;
    zi          = a;
    zf          = b;
    zg          = cg;
    zo          = d;
    clear_state = clr;
    out_ready   = early;
    modelStep(a, b, cg, d, clr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    zi = 16'($urandom);
    zf = 16'($urandom);
    zg = 16'($urandom);
    zo = 16'($urandom);
    clear_state = 1'($urandom);
    // The accept edge counts as the first cycle.
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", 16'(cycles), 16'd6);
    checkOutput("c_out", c_out, exp_c);
    checkOutput("h_out", h_out, exp_h);
    checkOutput("in_ready_busy", {15'b0, in_ready}, 16'h0000);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        if (poke) begin
          in_valid = 1'b1;
          zi = 16'($urandom);
          zf = 16'($urandom);
          zg = 16'($urandom);
          zo = 16'($urandom);
          clear_state = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("held_valid", {15'b0, out_valid}, 16'h0001);
        checkOutput("held_in_ready", {15'b0, in_ready}, 16'h0000);
        checkOutput("held_c_out", c_out, exp_c);
        checkOutput("held_h_out", h_out, exp_h);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("post_hs_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("post_hs_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("post_hs_c_out", c_out, exp_c);
    checkOutput("post_hs_h_out", h_out, exp_h);
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("rst_h_out", h_out, 16'h0000);
    checkOutput("rst_c_out", c_out, 16'h0000);
    rst = 1'b0;
    c_model = 0;

    // Fresh sequence, carried state, half gates.
    applyStimulus(16'h0400, 16'hFC00, 16'h0080, 16'h0400, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("t2_c_out", c_out, 16'h0080);
    checkOutput("t2_h_out", h_out, 16'h0080);
    applyStimulus(16'h0400, 16'h0400, 16'h0080, 16'h0400, 1'b0, 1'b0, 2, 1'b0);
    checkOutput("t3_c_out", c_out, 16'h0100);
    checkOutput("t3_h_out", h_out, 16'h0100);
    applyStimulus(16'h0000, 16'h0000, 16'h0100, 16'h0400, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("t4_c_out", c_out, 16'h0100);
    checkOutput("t4_h_out", h_out, 16'h0100);

    // Saturation: c climbs one unit per element until it pins at 0x7FFF.
    for (int n = 0; n < 130; n++) begin
      applyStimulus(16'h0400, 16'h0400, 16'h0100, 16'h0400, (n == 0), 1'b0, 0, 1'b0);
      if (n == 0) checkOutput("sat_first", c_out, 16'h0100);
      if (n == 126) checkOutput("sat_pre", c_out, 16'h7F00);
    end
    checkOutput("sat_c_out", c_out, 16'h7FFF);
    checkOutput("sat_h_out", h_out, 16'h0100);

    // Backpressure with junk on the input side, which must not be latched.
    applyStimulus(16'h0200, 16'hFF00, 16'h0040, 16'h0100, 1'b1, 1'b0, 10, 1'b1);
    applyStimulus(16'h0100, 16'h0300, 16'hFFC0, 16'h0200, 1'b0, 1'b0, 1, 1'b0);

    // Reset while in MULI: the element is dropped and c returns to zero.
    @(negedge clk);
    in_valid = 1'b1;
    zi = 16'h0400;
    zf = 16'h0400;
    zg = 16'h0100;
    zo = 16'h0400;
    clear_state = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("muli_out_valid", {15'b0, out_valid}, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    c_model = 0;
    checkOutput("midrst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("midrst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("midrst_c_out", c_out, 16'h0000);
    checkOutput("midrst_h_out", h_out, 16'h0000);
    applyStimulus(16'h0400, 16'h0400, 16'h0100, 16'h0400, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("midrst_next_c", c_out, 16'h0100);

    // Randomized elements over the full input range.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
